// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared defaults, FSM encoding and address helper for the result drain
package sa_pkg;

  localparam int SA_N      = 8;
  localparam int SA_ACC_W  = 20;
  localparam int SA_OUT_W  = 16;
  localparam int SA_ADDR_W = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic int unsigned rm_offset(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned n);
    return row * n + col;
  endfunction

endpackage

// File: rtl/sa_sat_conv.sv
// rtl/sa_sat_conv.sv - signed accumulator to result-word conversion (saturate or truncate)
module sa_sat_conv #(
  parameter int ACC_W = 20,
  parameter int OUT_W = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] res
);

  generate
    if (OUT_W == ACC_W) begin : g_ident
      assign res = acc;
    end else if (SAT) begin : g_sat
      // In range only when the dropped bits all match the kept sign bit.
      logic [ACC_W-OUT_W:0] top;
      logic                 ovf;
      assign top = acc[ACC_W-1:OUT_W-1];
      assign ovf = !((&top) || (~|top));
      assign res = !ovf          ? acc[OUT_W-1:0] :
                   acc[ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                   {1'b0, {(OUT_W-1){1'b1}}};
    end else begin : g_trunc
      assign res = acc[OUT_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/sa_result_drain.sv
// rtl/sa_result_drain.sv - drains the PE accumulator array row by row into result memory C
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int  N      = SA_N,
  parameter int  ACC_W  = SA_ACC_W,
  parameter int  OUT_W  = SA_OUT_W,
  parameter int  ADDR_W = SA_ADDR_W,
  parameter bit  SAT    = 1'b1,
  localparam int RW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sa_done,
  input  logic [ADDR_W-1:0] addr_mtxC,
  output logic [RW-1:0]    row_sel,
  input  logic [N*ACC_W-1:0] row_data,
  output logic             mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OUT_W-1:0] mem_wdata,
  input  logic             mem_ready,
  output logic             acc_clr,
  output logic             busy,
  output logic             drain_done
);

  logic [2:0]         state;
  logic [RW-1:0]      row;
  logic [RW-1:0]      col;
  logic [ADDR_W-1:0]  base;
  logic               sa_done_q;
  logic [N*ACC_W-1:0] row_buf;
  logic [ACC_W-1:0]   acc_sel;
  logic [OUT_W-1:0]   conv_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      base      <= '0;
      sa_done_q <= 1'b0;
      row_buf   <= '0;
    end else begin
      sa_done_q <= sa_done;
      case (state)
        ST_IDLE: begin
          if (sa_done && !sa_done_q) begin
            state <= ST_LOAD;
            base  <= addr_mtxC;
            row   <= '0;
            col   <= '0;
          end
        end
        ST_LOAD: begin
          row_buf <= row_data;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          if (mem_ready) begin
            if (col == RW'(N - 1)) begin
              col <= '0;
              // Row returns to 0 after the last row so row_sel idles at 0.
              if (row == RW'(N - 1)) begin
                row   <= '0;
                state <= ST_CLEAR;
              end else begin
                row   <= row + 1'b1;
                state <= ST_LOAD;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_CLEAR: state <= ST_DONE;
        ST_DONE: begin
          if (!sa_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign acc_sel = row_buf[col*ACC_W +: ACC_W];

  sa_sat_conv #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SAT   (SAT)
  ) u_conv (
    .acc (acc_sel),
    .res (conv_out)
  );

  assign row_sel    = row;
  assign mem_wen    = (state == ST_WRITE);
  assign mem_addr   = mem_wen ? base + ADDR_W'(rm_offset(32'(row), 32'(col), N)) : '0;
  assign mem_wdata  = mem_wen ? conv_out : '0;
  assign acc_clr    = (state == ST_CLEAR);
  assign busy       = (state == ST_LOAD) || (state == ST_WRITE) || (state == ST_CLEAR);
  assign drain_done = (state == ST_DONE);

endmodule

// File: tb/tb_sa_result_drain.sv
// tb/tb_sa_result_drain.sv - randomized self-checking bench for sa_result_drain
module tb_sa_result_drain;

  localparam int N      = 8;
  localparam int ACC_W  = 20;
  localparam int OUT_W  = 16;
  localparam int ADDR_W = 10;
  localparam int RW     = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sa_done;
  logic [ADDR_W-1:0]  addr_mtxC;
  logic               mem_ready;

  logic [RW-1:0]      row_sel,    t_row_sel;
  logic [N*ACC_W-1:0] row_data,   t_row_data;
  logic               mem_wen,    t_mem_wen;
  logic [ADDR_W-1:0]  mem_addr,   t_mem_addr;
  logic [OUT_W-1:0]   mem_wdata,  t_mem_wdata;
  logic               acc_clr,    t_acc_clr;
  logic               busy,       t_busy;
  logic               drain_done, t_drain_done;

  logic [ACC_W-1:0]   pe [N][N];
  int                 n_vec;
  int                 n_err;

  always #5 clk = ~clk;

  sa_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sa_done(sa_done), .addr_mtxC(addr_mtxC),
    .row_sel(row_sel), .row_data(row_data), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .acc_clr(acc_clr), .busy(busy),
    .drain_done(drain_done)
  );

  sa_result_drain #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .SAT(1'b0)) dut_trn (
    .clk(clk), .rst_n(rst_n), .sa_done(sa_done), .addr_mtxC(addr_mtxC),
    .row_sel(t_row_sel), .row_data(t_row_data), .mem_wen(t_mem_wen), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ready(mem_ready), .acc_clr(t_acc_clr), .busy(t_busy),
    .drain_done(t_drain_done)
  );

  always_comb begin
    row_data   = '0;
    t_row_data = '0;
    for (int c = 0; c < N; c++) begin
      row_data[c*ACC_W +: ACC_W]   = pe[row_sel][c];
      t_row_data[c*ACC_W +: ACC_W] = pe[t_row_sel][c];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_sat(input logic [ACC_W-1:0] a);
    int v;
    v = int'($signed(a));
    if (v > 2**(OUT_W-1) - 1) return {1'b0, {(OUT_W-1){1'b1}}};
    if (v < -(2**(OUT_W-1)))  return {1'b1, {(OUT_W-1){1'b0}}};
    return OUT_W'(v);
  endfunction

  function automatic logic [OUT_W-1:0] ref_trunc(input logic [ACC_W-1:0] a);
    return OUT_W'(a % (1 << OUT_W));
  endfunction

  function automatic logic [ACC_W-1:0] special_val(input int k);
    case (k)
      0: return 20'h7FFFF;
      1: return 20'h80000;
      2: return 20'hFFFFB;
      3: return 20'h12345;
      4: return 20'h08000;
      5: return 20'hF7FFF;
      6: return 20'h07FFF;
      default: return 20'hF8000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case ($urandom_range(0, 2))
          0: pe[r][c] = ACC_W'($urandom);
          1: pe[r][c] = ACC_W'($urandom_range(0, 65535)) - 20'd32768;
          default: pe[r][c] = special_val($urandom_range(0, 7));
        endcase
  endtask

  task automatic run_drain(input logic [ADDR_W-1:0] base, input int stall_mode,
                           input bit glitch, input bit drop_done);
    logic [ADDR_W-1:0] q_addr [$];
    logic [OUT_W-1:0]  q_sat [$];
    logic [OUT_W-1:0]  q_trn [$];
    int cyc, stalls, idx, held, first_wen, hold115;
    bit clr_seen, rdy;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        q_addr.push_back(base + ADDR_W'(r*N + c));
        q_sat.push_back(ref_sat(pe[r][c]));
        q_trn.push_back(ref_trunc(pe[r][c]));
      end
    cyc = 0; stalls = 0; idx = 0; held = 0; first_wen = -1; hold115 = 0; clr_seen = 0;
    addr_mtxC = base;
    sa_done   = 1'b1;
    mem_ready = 1'b1;
    tick();
    cyc = 1;
    check_eq("busy_in_load", busy, 1);
    check_eq("wen_in_load", mem_wen, 0);
    addr_mtxC = ADDR_W'($urandom);
    while (!clr_seen && cyc < 1000) begin
      case (stall_mode)
        1:       rdy = ($urandom_range(0, 3) != 0);
        2:       rdy = !(idx == 21 && held < 3);
        default: rdy = 1'b1;
      endcase
      mem_ready = rdy;
      if (glitch && cyc == 30) sa_done = 1'b0;
      if (glitch && cyc == 31) sa_done = 1'b1;
      if (drop_done && cyc == 10) sa_done = 1'b0;
      if (acc_clr) begin
        clr_seen = 1'b1;
        check_eq("clr_cycle", cyc, 1 + N*(N+1) + stalls);
        check_eq("writes_before_clr", idx, N*N);
        check_eq("wen_in_clear", mem_wen, 0);
        check_eq("busy_in_clear", busy, 1);
      end else begin
        if (mem_wen) begin
          if (idx >= N*N) begin
            check_eq("extra_write", idx, N*N - 1);
            break;
          end
          if (first_wen < 0) first_wen = cyc;
          check_eq("addr", mem_addr, q_addr[idx]);
          check_eq("wdata_sat", mem_wdata, q_sat[idx]);
          check_eq("wdata_trunc", t_mem_wdata, q_trn[idx]);
          if (mem_addr == 10'h115) hold115++;
          if (idx == 21) held++;
          if (rdy) idx++;
          else stalls++;
        end
        tick();
        cyc++;
      end
    end
    check_eq("acc_clr_seen", clr_seen, 1);
    check_eq("first_wen_cycle", first_wen, 2);
    if (stall_mode == 2) begin
      check_eq("hold_0x115", hold115, 4);
      check_eq("stall_count", stalls, 3);
    end
    mem_ready = 1'b1;
    tick();
    cyc++;
    check_eq("done_cycle", cyc, 2 + N*(N+1) + stalls);
    check_eq("drain_done", drain_done, 1);
    check_eq("drain_done_trn", t_drain_done, 1);
    check_eq("busy_in_done", busy, 0);
    check_eq("acc_clr_one_cycle", acc_clr, 0);
    check_eq("row_sel_after", row_sel, 0);
    if (sa_done) begin
      tick();
      check_eq("done_held", drain_done, 1);
      sa_done = 1'b0;
    end
    tick();
    check_eq("done_released", drain_done, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic run_reset_abort();
    int idx, cnt_wen, cnt_clr;
    bit hit;
    idx = 0; hit = 0; cnt_wen = 0; cnt_clr = 0;
    addr_mtxC = 10'h040;
    sa_done   = 1'b1;
    mem_ready = 1'b1;
    tick();
    for (int k = 0; k < 200 && !hit; k++) begin
      if (mem_wen) begin
        if (idx == 20) hit = 1'b1;
        else idx++;
      end
      if (!hit) tick();
    end
    check_eq("abort_reached_write20", hit, 1);
    check_eq("abort_addr", mem_addr, 10'h054);
    rst_n   = 1'b0;
    sa_done = 1'b0;
    tick();
    check_eq("abort_wen", mem_wen, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_row_sel", row_sel, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (mem_wen) cnt_wen++;
      if (acc_clr) cnt_clr++;
    end
    check_eq("abort_no_wen", cnt_wen, 0);
    check_eq("abort_no_clr", cnt_clr, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    sa_done   = 1'b1;
    addr_mtxC = 10'h3FF;
    mem_ready = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        pe[r][c] = ACC_W'(r*N + c);
    repeat (3) tick();
    check_eq("rst_row_sel", row_sel, 0);
    check_eq("rst_wen", mem_wen, 0);
    check_eq("rst_addr", mem_addr, 0);
    check_eq("rst_wdata", mem_wdata, 0);
    check_eq("rst_acc_clr", acc_clr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_drain_done", drain_done, 0);

    sa_done = 1'b0;
    rst_n   = 1'b1;
    repeat (4) tick();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_wen", mem_wen, 0);

    run_drain(10'h100, 0, 1'b0, 1'b0);
    run_drain(10'h100, 2, 1'b0, 1'b0);

    fill_random();
    pe[0][0] = 20'h7FFFF;
    pe[0][1] = 20'h80000;
    pe[0][2] = 20'hFFFFB;
    pe[0][3] = 20'h12345;
    run_drain(10'h3F0, 1, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_drain(ADDR_W'($urandom), 1, 1'b0, 1'($urandom_range(0, 1)));
    end

    fill_random();
    run_reset_abort();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
